// File: rtl/cordiccart2pol_gain_post.sv
// Post-multiplier stage for the cart2pol CORDIC gain: slot tags, multiplier ce, round/saturate, FWFT output FIFO.
// Define CORDIC_GAIN_ROUND_EN to add the half-LSB rounding term before the shift (default build truncates).
module cordiccart2pol_gain_post #(
   parameter int PROD_W     = 30,
   parameter int OUT_W      = 16,
   parameter int FRAC_SHIFT = 12,
   parameter int MUL_LAT    = 3,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              mul_ce,
   input  logic [PROD_W-1:0] mul_p,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [OUT_W-1:0]  out_data,
   output logic              out_sat,
   output logic [15:0]       sat_count
);

   localparam int SUM_W = PROD_W + 1;
   localparam int SH_W  = SUM_W - FRAC_SHIFT;
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

`ifdef CORDIC_GAIN_ROUND_EN
   localparam logic signed [SUM_W-1:0] ROUND_ADD = SUM_W'(2 ** (FRAC_SHIFT - 1));
`else
   localparam logic signed [SUM_W-1:0] ROUND_ADD = '0;
`endif

   localparam logic signed [SH_W-1:0] SAT_MAX = SH_W'(2 ** (OUT_W - 1) - 1);
   localparam logic signed [SH_W-1:0] SAT_MIN = ~SAT_MAX;

   logic [MUL_LAT-1:0]    tag;
   logic [OUT_W-1:0]      data_mem [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] sat_mem;
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [CNT_W-1:0]      count;
   logic                  fifo_full;
   logic                  push;
   logic                  pop;

   logic signed [SUM_W-1:0] sum;
   logic signed [SH_W-1:0]  shifted;
   logic [OUT_W-1:0]        scaled;
   logic                    scaled_sat;

   // ce only drops when the product at the pipe end has nowhere to go; out_ready is not involved
   assign fifo_full = (count == CNT_W'(FIFO_DEPTH));
   assign mul_ce    = !(tag[MUL_LAT-1] && fifo_full);
   assign in_ready  = mul_ce;
   assign push      = tag[MUL_LAT-1] && mul_ce;
   assign out_valid = (count != '0);
   assign pop       = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         tag <= '0;
      end else if (mul_ce) begin
         tag <= {tag[MUL_LAT-2:0], in_valid};
      end
   end

   // Widen by one bit so the rounding addend can never overflow the signed product
   always_comb begin
      sum        = $signed({mul_p[PROD_W-1], mul_p}) + ROUND_ADD;
      shifted    = SH_W'(sum >>> FRAC_SHIFT);
      scaled     = shifted[OUT_W-1:0];
      scaled_sat = 1'b0;
      if (shifted > SAT_MAX) begin
         scaled     = SAT_MAX[OUT_W-1:0];
         scaled_sat = 1'b1;
      end else if (shifted < SAT_MIN) begin
         scaled     = SAT_MIN[OUT_W-1:0];
         scaled_sat = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         data_mem[wr_ptr] <= scaled;
         sat_mem[wr_ptr]  <= scaled_sat;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         sat_count <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
         if (push && scaled_sat && (sat_count != 16'hFFFF)) begin
            sat_count <= sat_count + 16'd1;
         end
      end
   end

   // Gate the head so an empty FIFO presents zeros rather than unreset storage
   assign out_data = out_valid ? data_mem[rd_ptr] : '0;
   assign out_sat  = out_valid ? sat_mem[rd_ptr] : 1'b0;

endmodule

// File: tb/tb_cordiccart2pol_gain_post.sv
// Directed bench for cordiccart2pol_gain_post with a behavioural 3-stage ce-qualified multiplier in front.
module tb_cordiccart2pol_gain_post;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic        mul_ce;
   logic [29:0] mul_p;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic        out_sat;
   logic [15:0] sat_count;

   logic [15:0] din0;
   logic [12:0] din1;
   logic [15:0] a_r = '0;
   logic [12:0] b_r = '0;
   logic [29:0] p1  = '0;
   logic [29:0] p2  = '0;

   int pass_count  = 0;
   int fail_count  = 0;
   int check_count = 0;
   int sent;
   int recv;
   logic acc;
   logic seen;
   logic [15:0] exp_round;
   logic [15:0] exp_neg;

   cordiccart2pol_gain_post dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .mul_ce    (mul_ce),
      .mul_p     (mul_p),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_sat   (out_sat),
      .sat_count (sat_count)
   );

   always #5 clk = ~clk;

   // Signed x unsigned multiplier, three registers, all gated by ce
   always @(posedge clk) begin
      if (mul_ce) begin
         a_r <= din0;
         b_r <= din1;
         p1  <= {{14{a_r[15]}}, a_r} * {17'd0, b_r};
         p2  <= p1;
      end
   end
   assign mul_p = p2;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      check_count++;
      assert (obs === exp) pass_count++;
      else begin
         fail_count++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic apply_stimulus(input logic [15:0] a, input logic [12:0] b);
      in_valid = 1'b1;
      din0     = a;
      din1     = b;
      for (int i = 0; i < 100 && !in_ready; i++) tick;
      check("accept_ready", 32'(in_ready), 32'd1);
      tick;
      in_valid = 1'b0;
   endtask

   task automatic check_output(input string tag, input logic [15:0] exp_data, input logic exp_sat);
      for (int i = 0; i < 20 && !out_valid; i++) tick;
      check({tag, "_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_data"}, 32'(out_data), 32'(exp_data));
      check({tag, "_sat"}, 32'(out_sat), 32'(exp_sat));
      tick;
   endtask

   initial begin
`ifdef CORDIC_GAIN_ROUND_EN
      exp_round = 16'd2;
      exp_neg   = 16'hFDA1;
`else
      exp_round = 16'd1;
      exp_neg   = 16'hFDA0;
`endif
      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      din0      = '0;
      din1      = '0;
      tick;
      tick;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_out_sat", 32'(out_sat), 32'd0);
      check("rst_sat_count", 32'(sat_count), 32'd0);
      check("rst_mul_ce", 32'(mul_ce), 32'd1);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      reset = 1'b0;
      tick;

      $display("[TB] latency and basic scaling");
      apply_stimulus(16'd1000, 13'd2487);
      check("lat_e0", 32'(out_valid), 32'd0);
      tick;
      check("lat_e1", 32'(out_valid), 32'd0);
      tick;
      check("lat_e2", 32'(out_valid), 32'd0);
      tick;
      check("lat_e3_valid", 32'(out_valid), 32'd1);
      check("lat_e3_data", 32'(out_data), 32'd607);
      check("lat_e3_sat", 32'(out_sat), 32'd0);
      tick;
      check("lat_popped", 32'(out_valid), 32'd0);

      $display("[TB] rounding, boundaries and saturation");
      apply_stimulus(16'd2, 13'd3072);
      check_output("round_6144", exp_round, 1'b0);
      apply_stimulus(16'hFC18, 13'd2487);
      check_output("round_neg", exp_neg, 1'b0);
      apply_stimulus(16'h7FFF, 13'd4096);
      check_output("edge_max", 16'h7FFF, 1'b0);
      apply_stimulus(16'h8000, 13'd4096);
      check_output("edge_min", 16'h8000, 1'b0);
      check("edge_sat_count", 32'(sat_count), 32'd0);
      apply_stimulus(16'h7FFF, 13'd8191);
      check_output("sat_pos", 16'h7FFF, 1'b1);
      check("sat_count_1", 32'(sat_count), 32'd1);
      apply_stimulus(16'h8000, 13'd8191);
      check_output("sat_neg", 16'h8000, 1'b1);
      check("sat_count_2", 32'(sat_count), 32'd2);

      $display("[TB] backpressure stream of 10");
      out_ready = 1'b0;
      sent = 0;
      for (int c = 0; c < 14; c++) begin
         in_valid = (sent < 10);
         din0     = 16'(100 + sent);
         din1     = 13'd4096;
         acc      = in_valid && in_ready;
         tick;
         if (acc) sent++;
      end
      check("stall_accepted", 32'(sent), 32'd7);
      check("stall_mul_ce", 32'(mul_ce), 32'd0);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_head_valid", 32'(out_valid), 32'd1);
      check("stall_head_data", 32'(out_data), 32'd100);
      out_ready = 1'b1;
      check("stall_hold", 32'(mul_ce), 32'd0);
      recv = 0;
      for (int c = 0; c < 60 && recv < 10; c++) begin
         in_valid = (sent < 10);
         din0     = 16'(100 + sent);
         din1     = 13'd4096;
         acc      = in_valid && in_ready;
         if (out_valid) begin
            check("stream_data", 32'(out_data), 32'(100 + recv));
            recv++;
         end
         tick;
         if (acc) sent++;
         if (c == 0) check("stall_release", 32'(mul_ce), 32'd1);
      end
      in_valid = 1'b0;
      check("stream_sent", 32'(sent), 32'd10);
      check("stream_recv", 32'(recv), 32'd10);
      tick;
      tick;
      check("stream_no_dup", 32'(out_valid), 32'd0);

      $display("[TB] simultaneous push and pop at count 2");
      out_ready = 1'b0;
      apply_stimulus(16'd200, 13'd4096);
      apply_stimulus(16'd201, 13'd4096);
      apply_stimulus(16'd202, 13'd4096);
      tick;
      tick;
      check("pp_head0", 32'(out_data), 32'd200);
      out_ready = 1'b1;
      tick;
      check("pp_head1", 32'(out_data), 32'd201);
      tick;
      check("pp_head2_valid", 32'(out_valid), 32'd1);
      check("pp_head2", 32'(out_data), 32'd202);
      tick;
      check("pp_empty", 32'(out_valid), 32'd0);

      $display("[TB] reset with work in flight");
      out_ready = 1'b0;
      apply_stimulus(16'd300, 13'd4096);
      apply_stimulus(16'd301, 13'd4096);
      apply_stimulus(16'd302, 13'd4096);
      apply_stimulus(16'd303, 13'd4096);
      apply_stimulus(16'd304, 13'd4096);
      check("mid_pre_valid", 32'(out_valid), 32'd1);
      reset = 1'b1;
      tick;
      reset = 1'b0;
      check("mid_out_valid", 32'(out_valid), 32'd0);
      check("mid_out_data", 32'(out_data), 32'd0);
      check("mid_sat_count", 32'(sat_count), 32'd0);
      check("mid_mul_ce", 32'(mul_ce), 32'd1);
      out_ready = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 10; c++) begin
         tick;
         if (out_valid) seen = 1'b1;
      end
      check("mid_no_stale", 32'(seen), 32'd0);

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
